// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle main controller: opcodes, functs,
// FSM states, ALU/write-back selects and the one-hot instruction class.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DM   = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  typedef struct packed {
    logic is_addu;
    logic is_subu;
    logic is_ori;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_lui;
    logic is_jal;
    logic is_jr;
    logic is_nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct of IR to a one-hot class.
// Anything not recognised, including the all-zero word, is classed as nop.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: cls.is_addu = 1'b1;
          FN_SUBU: cls.is_subu = 1'b1;
          FN_JR:   cls.is_jr   = 1'b1;
          default: cls.is_nop  = 1'b1;
        endcase
      end
      OP_ORI:  cls.is_ori = 1'b1;
      OP_LW:   cls.is_lw  = 1'b1;
      OP_SW:   cls.is_sw  = 1'b1;
      OP_BEQ:  cls.is_beq = 1'b1;
      OP_LUI:  cls.is_lui = 1'b1;
      OP_JAL:  cls.is_jal = 1'b1;
      default: cls.is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with Moore
// outputs decoded from state and IR, one PCEn pulse per retired instruction.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  output logic             PCEn,
  output logic             BEQ,
  output logic             JAL,
  output logic             JR,
  output logic             IREn,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [2:0]       ALUOp,
  output logic             ExtOp,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCnt
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;

  // The IFU qualifies beq with Zero itself, so the controller never consumes it.
  logic        zero_unused;
  logic [19:0] ir_fields_unused;
  assign zero_unused      = Zero;
  assign ir_fields_unused = ir_q[25:6];

  mc_decode u_decode (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .cls    (cls)
  );

  always_comb begin
    state_d = S_FETCH;
    ir_d    = ir_q;
    cnt_d   = cnt_q + CNT_W'(PCEn);
    case (state_q)
      S_FETCH: begin
        ir_d    = Instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls.is_jal)                    state_d = S_WB;
        else if (cls.is_jr || cls.is_nop)  state_d = S_FETCH;
        else                               state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cls.is_beq)                    state_d = S_FETCH;
        else if (cls.is_lw || cls.is_sw)   state_d = S_MEM;
        else                               state_d = S_WB;
      end
      S_MEM:   state_d = cls.is_lw ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PCEn     = 1'b0;
    BEQ      = 1'b0;
    JAL      = 1'b0;
    JR       = 1'b0;
    IREn     = 1'b0;
    RegWrite = 1'b0;
    RegDst   = DST_RT;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = WB_ALU;
    if (!Reset) begin
      case (state_q)
        S_FETCH:  IREn = 1'b1;
        S_DECODE: begin
          if (cls.is_jr) begin
            PCEn = 1'b1;
            JR   = 1'b1;
          end else if (cls.is_nop) begin
            PCEn = 1'b1;
          end
        end
        S_EXEC: begin
          if (cls.is_beq) begin
            PCEn = 1'b1;
            BEQ  = 1'b1;
          end
        end
        S_MEM: begin
          if (cls.is_sw) begin
            PCEn     = 1'b1;
            MemWrite = 1'b1;
          end
        end
        S_WB: begin
          PCEn     = 1'b1;
          RegWrite = 1'b1;
          JAL      = cls.is_jal;
          if (cls.is_addu || cls.is_subu) begin
            RegDst = DST_RD;
          end else if (cls.is_lw) begin
            MemtoReg = WB_DM;
          end else if (cls.is_jal) begin
            RegDst   = DST_RA;
            MemtoReg = WB_PC4;
          end
        end
        default: ;
      endcase
      // ALU controls are held from EXEC onwards so the result is stable at write-back.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        if (cls.is_subu || cls.is_beq) begin
          ALUOp = ALU_SUB;
        end else if (cls.is_ori) begin
          ALUSrc = 1'b1;
          ALUOp  = ALU_OR;
        end else if (cls.is_lui) begin
          ALUSrc = 1'b1;
          ALUOp  = ALU_LUI;
        end else if (cls.is_lw || cls.is_sw) begin
          ALUSrc = 1'b1;
          ExtOp  = 1'b1;
        end
      end
    end
  end

  assign State    = state_q;
  assign InstrCnt = cnt_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller that drives the IFU's next-PC controls (BEQ, JAL, JR) and a PC write enable. It consumes the fetched instruction word (IFU RD) and the ALU Zero flag. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues exactly one PC update per instruction. It sits between IFU, GRF, ALU and DM in the P4 datapath, upgraded to multi-cycle.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Instr  in  32  instruction word from IFU RD
Zero  in  1  ALU equality flag, valid in EXEC
PCEn  out  1  PC write enable to IFU, one pulse per instruction
BEQ  out  1  IFU branch select; meaningful only with PCEn
JAL  out  1  IFU jump-to-imm26 select; meaningful only with PCEn
JR  out  1  IFU jump-to-ra select; meaningful only with PCEn
IREn  out  1  instruction register load strobe
RegWrite  out  1  GRF write enable
RegDst  out  2  0=rt, 1=rd, 2=$31
ALUSrc  out  1  0=rt data, 1=extended imm16
ALUOp  out  3  0=add, 1=sub, 2=or, 3=lui (imm<<16)
ExtOp  out  1  1=sign-extend imm16, 0=zero-extend
MemWrite  out  1  DM write enable
MemtoReg  out  2  0=ALU, 1=DM, 2=PC4
State  out  3  current state encoding, for debug
InstrCnt  out  CNT_W  retired-instruction count

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high.
- Reset: State=FETCH(0), IR=0, InstrCnt=0. All outputs are 0 while Reset is high, including IREn.
- Reset mid-instruction: the instruction is aborted. No PCEn, RegWrite or MemWrite pulse occurs in the reset cycle.
- IR is an internal 32-bit register, loaded from Instr on the FETCH edge. All decode uses IR, never the live Instr.
- Supported: addu, subu, ori, lw, sw, beq, lui, jal, jr.
- Instr==0 and any unknown opcode/funct are treated as nop.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Encodings 5-7 are illegal: next state is FETCH, all outputs are 0.
- Outputs are Moore: decoded from State and IR only.
- Zero is sampled only in EXEC for beq.
- FETCH: IREn=1, then go to DECODE.
- DECODE, jr: PCEn=1, JR=1, then FETCH (2 cycles total).
- DECODE, nop/unknown: PCEn=1, then FETCH (2 cycles).
- DECODE, jal: go to WB.
- DECODE, all others: go to EXEC.
- EXEC: ALUSrc/ALUOp/ExtOp are driven per instruction.
- EXEC, beq: ALUOp=sub, BEQ=1, PCEn=1, then FETCH (3 cycles). The IFU itself qualifies the branch with Zero.
- EXEC, lw/sw: ALUOp=add, ExtOp=1, ALUSrc=1, then MEM.
- EXEC, addu/subu/ori/lui: go to WB.
- MEM, sw: MemWrite=1, PCEn=1, then FETCH (4 cycles).
- MEM, lw: go to WB.
- WB: RegWrite=1 and PCEn=1, then FETCH.
- WB write-back select per instruction:
  - addu/subu: RegDst=1, MemtoReg=0.
  - ori/lui: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
  - jal: RegDst=2, MemtoReg=2, JAL=1.
- WB cycle counts: R-type and ori/lui take 4 cycles, lw takes 5, jal takes 3.
- ALU controls (ALUSrc/ALUOp/ExtOp) stay asserted from EXEC through MEM/WB, so ALU output is stable at write-back.
- PCEn is high for exactly one cycle per instruction, always in the last state.
- InstrCnt increments on every clock edge where PCEn=1. It wraps modulo 2^CNT_W with no saturation.
- BEQ, JAL and JR are mutually exclusive, and each is 0 whenever PCEn=0.

Decomposition:
- Shared package: opcode and funct constants (R=000000, ORI=001101, LW=100011, SW=101011, BEQ=000100, LUI=001111, JAL=000011; ADDU=100001, SUBU=100011, JR=001000).
- Also in the package: state encodings, ALUOp/RegDst/MemtoReg encodings.
- Sub-module mc_decode: purely combinational. Maps IR to one-hot instruction class (is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, is_jr, is_nop).
- mc_ctrl holds the FSM, IR, counter and output decode.

Test Plan:
- Reset held 2 cycles, then release with Instr=0x00221821 (addu $3,$1,$2) → states 0,1,2,4. RegWrite=1, RegDst=1, PCEn=1 in cycle 4 only. InstrCnt 0→1.
- Instr=0x8C020004 (lw) then 0xAC020008 (sw) → lw: 5 cycles, MemtoReg=1, RegWrite in WB. sw: 4 cycles, MemWrite=1 with PCEn in MEM, RegWrite never set. InstrCnt=2.
- Instr=0x10220001 (beq) with Zero=1, then rerun with Zero=0 → both: BEQ=1, PCEn=1 in EXEC (cycle 3), RegWrite and MemWrite stay 0.
- Instr=0x0C000003 (jal) then 0x03E00008 (jr $31) → jal: 3 cycles, WB has RegDst=2, MemtoReg=2, JAL=1, PCEn=1. jr: 2 cycles, JR=1, PCEn=1 in DECODE.
- lw in MEM state, assert Reset asynchronously mid-cycle → State=0 immediately, all outputs 0, no RegWrite pulse. After release, IR reloads and InstrCnt is unchanged at 0.
- Instr=0xFC000000 (unknown) and 0x00000000 → each retires in 2 cycles with PCEn only. Preload InstrCnt path to all-ones, retire one more → wraps to 0.
